cog_ctrx: RTL and testbench

COG_CTRX -- requirements
Module: cog_ctrx

---
 rtl/cog_ctrx_if.sv | 27 ++
 rtl/cog_ctrx.sv | 186 ++++++++++++++++++
 tb/tb_cog_ctrx.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cog_ctrx_if.sv
// Register bus of the cog counter block: write strobes, channel select, event
// clears and the combinational read-back of the selected channel.
interface cog_ctrx_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
);
  logic                setctr;
  logic                setfrq;
  logic                setphs;
  logic                setper;
  logic [1:0]          sel;
  logic [31:0]         data;
  logic [CHANNELS-1:0] clrevt;
  logic [WIDTH:0]      phs_rd;
  logic [WIDTH-1:0]    cap_rd;
  logic [CHANNELS-1:0] evt;

  modport master (
    output setctr, setfrq, setphs, setper, sel, data, clrevt,
    input  phs_rd, cap_rd, evt
  );

  modport slave (
    input  setctr, setfrq, setphs, setper, sel, data, clrevt,
    output phs_rd, cap_rd, evt
  );
endinterface

// File: rtl/cog_ctrx.sv
// Multi-channel cog counter: NCO, duty, PWM, level/edge counting and capture.
// Each channel owns ctr/frq/per/phs/cap, a 2-bit pin history and a sticky event.
module cog_ctrx #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int PINS     = 32
) (
  input  logic            clk_cog,
  input  logic            nres,
  cog_ctrx_if.slave       bus,
  input  logic [PINS-1:0] pin_in,
  output logic [PINS-1:0] pin_out
);

  localparam logic [3:0] MODE_NCO_SE    = 4'd1;
  localparam logic [3:0] MODE_NCO_DIFF  = 4'd2;
  localparam logic [3:0] MODE_DUTY_SE   = 4'd3;
  localparam logic [3:0] MODE_DUTY_DIFF = 4'd4;
  localparam logic [3:0] MODE_PWM       = 4'd5;
  localparam logic [3:0] MODE_LEVEL_HI  = 4'd6;
  localparam logic [3:0] MODE_LEVEL_LO  = 4'd7;
  localparam logic [3:0] MODE_EDGE_RISE = 4'd8;
  localparam logic [3:0] MODE_EDGE_FALL = 4'd9;
  localparam logic [3:0] MODE_CAPTURE   = 4'd10;

  // Pins are widened to 32 so any 5-bit index is legal; indices >= PINS see 0
  // on input and land in bits that are dropped on output.
  logic [31:0]            pin_in_ext;
  logic [3:0][WIDTH:0]    phs_all;
  logic [3:0][WIDTH-1:0]  cap_all;
  logic [3:0][31:0]       drive_all;
  logic [3:0]             evt_all;
  logic [31:0]            pin_all;
  logic                   unused_top;

  assign pin_in_ext = 32'(pin_in);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      if (gi < CHANNELS) begin : g_live
        logic [31:0]      ctr_reg, ctr_next;
        logic [WIDTH-1:0] frq_reg, frq_next;
        logic [WIDTH-1:0] per_reg, per_next;
        logic [WIDTH-1:0] cap_reg, cap_next;
        logic [WIDTH:0]   phs_reg, phs_next;
        logic [WIDTH:0]   sum;
        logic [1:0]       dly_reg, dly_next;
        logic             evt_reg, evt_next;
        logic [3:0]       mode;
        logic [4:0]       a_idx, b_idx;
        logic             wr_hit, rise, fall, active;
        logic             a_out, b_out, evt_carry, evt_cap;
        logic             unused_ctr;

        assign mode       = ctr_reg[29:26];
        assign b_idx      = ctr_reg[12:8];
        assign a_idx      = ctr_reg[4:0];
        assign unused_ctr = &{1'b0, ctr_reg[31:30], ctr_reg[25:13], ctr_reg[7:5]};
        assign wr_hit     = (bus.sel == 2'(gi));
        assign sum        = {1'b0, phs_reg[WIDTH-1:0]} + {1'b0, frq_reg};
        assign rise       = (dly_reg == 2'b01);
        assign fall       = (dly_reg == 2'b10);
        assign active     = (mode != 4'd0) && (mode <= MODE_CAPTURE);

        always_comb begin
          ctr_next  = ctr_reg;
          frq_next  = frq_reg;
          per_next  = per_reg;
          cap_next  = cap_reg;
          phs_next  = phs_reg;
          dly_next  = dly_reg;
          evt_carry = 1'b0;
          evt_cap   = 1'b0;
          a_out     = 1'b0;
          b_out     = 1'b0;

          if (active) begin
            dly_next = {dly_reg[0], pin_in_ext[a_idx]};
          end

          case (mode)
            MODE_NCO_SE, MODE_NCO_DIFF: begin
              phs_next  = sum;
              evt_carry = sum[WIDTH];
              a_out     = phs_reg[WIDTH-1];
              b_out     = (mode == MODE_NCO_DIFF) && !phs_reg[WIDTH-1];
            end
            MODE_DUTY_SE, MODE_DUTY_DIFF: begin
              phs_next  = sum;
              evt_carry = sum[WIDTH];
              a_out     = phs_reg[WIDTH];
              b_out     = (mode == MODE_DUTY_DIFF) && !phs_reg[WIDTH];
            end
            MODE_PWM: begin
              // Period is per+1 cycles; per == 0 pins phs at 0 and wraps every cycle.
              a_out = (phs_reg[WIDTH-1:0] < frq_reg);
              if (phs_reg[WIDTH-1:0] == per_reg) begin
                phs_next  = '0;
                evt_carry = 1'b1;
              end else begin
                phs_next = {1'b0, phs_reg[WIDTH-1:0]} + (WIDTH+1)'(1);
              end
            end
            MODE_LEVEL_HI: begin
              if (dly_reg[0]) phs_next = sum;
            end
            MODE_LEVEL_LO: begin
              if (!dly_reg[0]) phs_next = sum;
            end
            MODE_EDGE_RISE: begin
              if (rise) phs_next = sum;
            end
            MODE_EDGE_FALL: begin
              if (fall) phs_next = sum;
            end
            MODE_CAPTURE: begin
              phs_next = sum;
              if (rise) begin
                cap_next = phs_reg[WIDTH-1:0];
                evt_cap  = 1'b1;
              end
            end
            default: ;
          endcase

          // A direct phs write wins over this cycle's accumulation and its carry.
          if (wr_hit) begin
            if (bus.setctr) ctr_next = bus.data;
            if (bus.setfrq) frq_next = bus.data[WIDTH-1:0];
            if (bus.setper) per_next = bus.data[WIDTH-1:0];
            if (bus.setphs) begin
              phs_next  = {1'b0, bus.data[WIDTH-1:0]};
              evt_carry = 1'b0;
            end
          end

          evt_next = (evt_reg & ~bus.clrevt[gi]) | evt_carry | evt_cap;
        end

        always_ff @(posedge clk_cog or negedge nres) begin
          if (!nres) begin
            ctr_reg <= '0;
            frq_reg <= '0;
            per_reg <= '0;
            cap_reg <= '0;
            phs_reg <= '0;
            dly_reg <= '0;
            evt_reg <= 1'b0;
          end else begin
            ctr_reg <= ctr_next;
            frq_reg <= frq_next;
            per_reg <= per_next;
            cap_reg <= cap_next;
            phs_reg <= phs_next;
            dly_reg <= dly_next;
            evt_reg <= evt_next;
          end
        end

        assign phs_all[gi]   = phs_reg;
        assign cap_all[gi]   = cap_reg;
        assign evt_all[gi]   = evt_reg;
        assign drive_all[gi] = (32'(a_out) << a_idx) | (32'(b_out) << b_idx);
      end else begin : g_absent
        // Unpopulated slots read back as zero and drive no pins.
        assign phs_all[gi]   = '0;
        assign cap_all[gi]   = '0;
        assign evt_all[gi]   = 1'b0;
        assign drive_all[gi] = '0;
      end
    end
  endgenerate

  assign bus.phs_rd = phs_all[bus.sel];
  assign bus.cap_rd = cap_all[bus.sel];
  assign bus.evt    = evt_all[CHANNELS-1:0];

  always_comb begin
    pin_all = drive_all[0] | drive_all[1] | drive_all[2] | drive_all[3];
  end

  assign pin_out    = pin_all[PINS-1:0];
  assign unused_top = &{1'b0, bus.data, pin_all, evt_all};

endmodule

// File: tb/tb_cog_ctrx.sv
// Directed bench for cog_ctrx: a cycle model derived from the counter rules is
// compared every cycle, plus hand-computed checks for each scenario.
`timescale 1ns/1ps
module tb_cog_ctrx;
  localparam int NCH = 2;
  localparam int W   = 32;
  localparam int NP  = 16;

  localparam logic [3:0] S_CTR = 4'b1000;
  localparam logic [3:0] S_FRQ = 4'b0100;
  localparam logic [3:0] S_PHS = 4'b0010;
  localparam logic [3:0] S_PER = 4'b0001;

  logic          clk_cog = 1'b0;
  logic          nres;
  logic [NP-1:0] pin_in;
  logic [NP-1:0] pin_out;

  cog_ctrx_if #(.CHANNELS(NCH), .WIDTH(W)) bus ();

  cog_ctrx #(.CHANNELS(NCH), .WIDTH(W), .PINS(NP)) dut (
    .clk_cog (clk_cog),
    .nres    (nres),
    .bus     (bus),
    .pin_in  (pin_in),
    .pin_out (pin_out)
  );

  always #5 clk_cog = ~clk_cog;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  // Model state: programmed registers, accumulator with its carry, the last two
  // samples of the A pin, and the sticky event.
  logic [31:0]  m_ctr   [NCH];
  logic [W-1:0] m_frq   [NCH];
  logic [W-1:0] m_per   [NCH];
  logic [W-1:0] m_cap   [NCH];
  logic [W-1:0] m_acc   [NCH];
  bit           m_carry [NCH];
  bit           m_seen  [NCH];
  bit           m_prev  [NCH];
  bit           m_evt   [NCH];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrv(input int mode, input int b, input int a);
    return (32'(mode) << 26) | (32'(b) << 8) | 32'(a);
  endfunction

  task automatic model_step();
    logic [31:0] pins32;
    pins32 = 32'(pin_in);
    if (!nres) begin
      for (int c = 0; c < NCH; c++) begin
        m_ctr[c] = '0; m_frq[c] = '0; m_per[c] = '0; m_cap[c] = '0; m_acc[c] = '0;
        m_carry[c] = 0; m_seen[c] = 0; m_prev[c] = 0; m_evt[c] = 0;
      end
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      int           mode, apin;
      bit           a_now, rise, fall, adds, wrap, capt, ncarry;
      logic [W:0]   total;
      logic [W-1:0] nacc;
      mode   = int'(m_ctr[c][29:26]);
      apin   = int'(m_ctr[c][4:0]);
      a_now  = pins32[apin];
      rise   = m_seen[c] && !m_prev[c];
      fall   = !m_seen[c] && m_prev[c];
      adds   = (mode >= 1 && mode <= 4) || mode == 10 || (mode == 6 && m_seen[c]) ||
               (mode == 7 && !m_seen[c]) || (mode == 8 && rise) || (mode == 9 && fall);
      capt   = (mode == 10) && rise;
      wrap   = 0;
      nacc   = m_acc[c];
      ncarry = m_carry[c];
      if (adds) begin
        total  = {1'b0, m_acc[c]} + {1'b0, m_frq[c]};
        nacc   = total[W-1:0];
        ncarry = total[W];
        wrap   = (mode <= 4) && total[W];
      end
      if (mode == 5) begin
        if (m_acc[c] == m_per[c]) begin
          nacc = '0; ncarry = 0; wrap = 1;
        end else begin
          total  = {1'b0, m_acc[c]} + 1;
          nacc   = total[W-1:0];
          ncarry = total[W];
        end
      end
      if (capt) m_cap[c] = m_acc[c];
      if (int'(bus.sel) == c) begin
        if (bus.setctr) m_ctr[c] = bus.data;
        if (bus.setfrq) m_frq[c] = bus.data[W-1:0];
        if (bus.setper) m_per[c] = bus.data[W-1:0];
        if (bus.setphs) begin
          nacc = bus.data[W-1:0]; ncarry = 0; wrap = 0;
        end
      end
      m_evt[c] = (m_evt[c] && !bus.clrevt[c]) || wrap || capt;
      if (mode >= 1 && mode <= 10) begin
        m_prev[c] = m_seen[c];
        m_seen[c] = a_now;
      end
      m_acc[c]   = nacc;
      m_carry[c] = ncarry;
    end
  endtask

  task automatic do_compare();
    logic [31:0]   exp_all;
    logic [W:0]    ep;
    logic [W-1:0]  ec;
    logic [NCH-1:0] ee;
    int            s;
    exp_all = '0;
    for (int c = 0; c < NCH; c++) begin
      int mode;
      bit a, b;
      mode = int'(m_ctr[c][29:26]);
      a = 0;
      if (mode == 1 || mode == 2) a = m_acc[c][W-1];
      if (mode == 3 || mode == 4) a = m_carry[c];
      if (mode == 5) a = (m_acc[c] < m_frq[c]);
      b = (mode == 2 || mode == 4) && !a;
      exp_all = exp_all | (32'(a) << m_ctr[c][4:0]) | (32'(b) << m_ctr[c][12:8]);
      ee[c] = m_evt[c];
    end
    s  = int'(bus.sel);
    ep = '0;
    ec = '0;
    if (s < NCH) begin
      ep = {m_carry[s], m_acc[s]};
      ec = m_cap[s];
    end
    chk("pin_out", longint'(pin_out), longint'(exp_all[NP-1:0]));
    chk("evt", longint'(bus.evt), longint'(ee));
    chk("phs_rd", longint'(bus.phs_rd), longint'(ep));
    chk("cap_rd", longint'(bus.cap_rd), longint'(ec));
  endtask

  initial forever begin
    @(posedge clk_cog or negedge nres);
    model_step();
  end

  initial forever begin
    @(negedge clk_cog);
    if (cmp_en) do_compare();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_cog);
      #2;
    end
  endtask

  // stb = {setctr, setfrq, setphs, setper}; the write lands on the next edge.
  task automatic wr(input logic [3:0] stb, input int ch, input logic [31:0] val);
    bus.sel  = 2'(ch);
    bus.data = val;
    {bus.setctr, bus.setfrq, bus.setphs, bus.setper} = stb;
    tick();
    {bus.setctr, bus.setfrq, bus.setphs, bus.setper} = 4'b0000;
  endtask

  initial begin
    logic [7:0] pat;
    int         cnt_a, cnt_e;

    nres = 1'b1;
    pin_in = '0;
    bus.sel = '0;
    bus.data = '0;
    bus.clrevt = '0;
    {bus.setctr, bus.setfrq, bus.setphs, bus.setper} = 4'b0000;
    #1 nres = 1'b0;
    #1;
    chk("reset pin_out", longint'(pin_out), 0);
    chk("reset evt", longint'(bus.evt), 0);
    chk("reset phs_rd", longint'(bus.phs_rd), 0);
    chk("reset cap_rd", longint'(bus.cap_rd), 0);
    cmp_en = 1'b1;
    tick(2);
    nres = 1'b1;
    tick();

    // NCO single, quarter-scale frq: A toggles every 2 cycles, carry every 4.
    wr(S_FRQ, 0, 32'h4000_0000);
    wr(S_CTR, 0, ctrv(1, 0, 0));
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat[i] = pin_out[0];
      if (i == 3) chk("nco evt before carry", longint'(bus.evt[0]), 0);
      if (i == 4) chk("nco evt at carry", longint'(bus.evt[0]), 1);
      tick();
    end
    chk("nco A pattern", longint'(pat), 8'hCC);
    bus.clrevt = 2'b01;
    cnt_e = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt_e += int'(bus.evt[0]);
    end
    chk("nco evt pulses", cnt_e, 2);
    bus.clrevt = 2'b00;
    wr(S_CTR, 0, 0);

    // PWM ch1: per 9, frq 3, events cleared continuously.
    wr(S_PER, 1, 9);
    wr(S_FRQ, 1, 3);
    bus.clrevt = 2'b10;
    wr(S_CTR, 1, ctrv(5, 1, 1));
    cnt_a = 0;
    cnt_e = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_a += int'(pin_out[1]);
      cnt_e += int'(bus.evt[1]);
      tick();
    end
    chk("pwm A high count", cnt_a, 6);
    chk("pwm wrap pulses", cnt_e, 1);
    wr(S_FRQ | S_PHS | S_PER, 1, 0);
    tick();
    cnt_a = 0;
    cnt_e = 0;
    for (int i = 0; i < 8; i++) begin
      cnt_a += int'(pin_out[1]);
      cnt_e += int'(bus.evt[1]);
      tick();
    end
    chk("pwm per0 A count", cnt_a, 0);
    chk("pwm per0 evt count", cnt_e, 8);
    wr(S_CTR, 1, 0);
    bus.clrevt = 2'b11;
    tick();
    bus.clrevt = 2'b00;

    // Rising-edge count on pin 2, five pulses.
    wr(S_FRQ, 0, 1);
    wr(S_PHS, 0, 0);
    wr(S_CTR, 0, ctrv(8, 2, 2));
    tick(2);
    for (int k = 0; k < 5; k++) begin
      pin_in[2] = 1'b1;
      tick();
      if (k == 0) chk("edge count 1 cycle after rise", longint'(bus.phs_rd), 0);
      tick();
      if (k == 0) chk("edge count 2 cycles after rise", longint'(bus.phs_rd), 1);
      pin_in[2] = 1'b0;
      tick(2);
    end
    chk("edge count total", longint'(bus.phs_rd), 5);
    wr(S_CTR, 0, 0);

    // Capture on ch1: preset 100, rise detected 7 cycles after enabling.
    wr(S_FRQ, 1, 1);
    wr(S_PHS, 1, 100);
    wr(S_CTR, 1, ctrv(10, 3, 3));
    tick(5);
    pin_in[3] = 1'b1;
    tick();
    bus.clrevt = 2'b10;
    tick();
    chk("capture value", longint'(bus.cap_rd), 106);
    chk("capture evt with clear", longint'(bus.evt[1]), 1);
    tick();
    chk("capture evt cleared", longint'(bus.evt[1]), 0);
    bus.clrevt = 2'b00;
    pin_in[3] = 1'b0;
    wr(S_CTR, 1, 0);

    // setphs landing on the cycle an NCO carry would occur.
    bus.clrevt = 2'b11;
    tick();
    bus.clrevt = 2'b00;
    wr(S_FRQ, 0, 32'h4000_0000);
    wr(S_PHS, 0, 32'hC000_0000);
    wr(S_CTR, 0, ctrv(1, 0, 0));
    wr(S_PHS, 0, 32'h1234_5678);
    chk("setphs over carry", longint'(bus.phs_rd), 64'h1234_5678);
    chk("setphs no evt", longint'(bus.evt[0]), 0);
    tick(5);

    // Reset mid-count with a write pending.
    bus.sel = 2'd0;
    bus.data = ctrv(1, 4, 4);
    bus.setctr = 1'b1;
    nres = 1'b0;
    #1;
    chk("midreset pin_out", longint'(pin_out), 0);
    chk("midreset evt", longint'(bus.evt), 0);
    chk("midreset phs_rd", longint'(bus.phs_rd), 0);
    tick();
    bus.setctr = 1'b0;
    nres = 1'b1;
    tick(4);
    chk("after reset phs_rd", longint'(bus.phs_rd), 0);
    chk("after reset pin_out", longint'(pin_out), 0);

    // Writes to an unpopulated channel must not touch anything.
    wr(S_CTR | S_FRQ | S_PHS | S_PER, 3, 32'h0400_0005);
    tick(3);
    for (int s = 0; s < 3; s++) begin
      bus.sel = 2'(s);
      #1;
      chk("sel3 write phs_rd", longint'(bus.phs_rd), 0);
    end
    chk("sel3 write pin_out", longint'(pin_out), 0);

    // Differential NCO with A index beyond PINS: only B (pin 5) may move.
    wr(S_FRQ, 0, 32'h4000_0000);
    wr(S_CTR, 0, ctrv(2, 5, 20));
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      chk("offbus A pins", longint'(pin_out & ~16'h0020), 0);
      cnt_a += int'(pin_out[5]);
      tick();
    end
    chk("diff B high count", cnt_a, 4);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
